dmem_access_unit: RTL
=====================

# dmem_access_unit

- Memory-stage load/store unit: sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts RV32I load/store requests into word-wide handshaked transactions on the data-memory bus, stalling the pipeline meanwhile.
- Returns aligned, sign/zero-extended load data to the MEM/WB register's DMEM_OUT input and drives the pipeline-wide BUSYWAIT.

## Interface
- TIMEOUT_CYCLES, 64, WAIT-state cycles before abort (only with DMEM_TIMEOUT_EN); range 2..1023.
- CLK  in  1  sole clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- MEM_READ  in  1  load request from EX/MEM.
- MEM_WRITE  in  1  store request from EX/MEM.
- FUNC3  in  3  RV32I load/store width code.
- ADDRESS  in  32  byte address (ALU result).
- WRITE_DATA  in  32  store source (rs2).
- DMEM_OUT  out  32  extended load data; feeds MEM/WB IN_DMEM_OUT.
- BUSYWAIT  out  1  pipeline stall; high freezes all pipeline registers.
- MISALIGNED  out  1  access not issued (misaligned, illegal FUNC3, or read+write together); combinational, held while the request is held.
- BUS_ERROR  out  1  one-cycle pulse on timeout abort.
- MEM_REQ  out  1  bus request.
- MEM_WE  out  1  1 = write.
- MEM_ADDR  out  30  word address, ADDRESS[31:2].
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  lane-replicated store data.
- MEM_RDATA  in  32  read word.
- MEM_ACK  in  1  completion; RDATA valid in the same cycle.

## Operation
- FSM states:
  - IDLE -> WAIT on a valid request (READ xor WRITE, legal FUNC3, aligned).
  - WAIT -> DONE on MEM_ACK.
  - DONE -> IDLE unconditionally.
- BUSYWAIT = (IDLE and valid request) or WAIT. It is low in DONE, so the pipeline advances exactly once per access.
- MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE and MEM_WDATA come from registers captured on the IDLE->WAIT edge. They are held stable throughout WAIT. MEM_REQ is high only in WAIT; other bus outputs are 0 outside WAIT.
- Loads (FUNC3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU): on ACK, select the byte/half at ADDRESS[1:0], extend it, and register it into the data register.
  - DMEM_OUT = data register in DONE, 0 otherwise.
  - Stores leave the data register at 0.
- Stores (000 SB, 001 SH, 010 SW):
  - SB: BE = 0001<<ADDRESS[1:0], WDATA = {4{rs2[7:0]}}.
  - SH: BE = 0011<<(2*ADDRESS[1]), WDATA = {2{rs2[15:0]}}.
  - SW: BE = 1111, WDATA = rs2.
- Misalignment: half with ADDRESS[0]=1, word with ADDRESS[1:0]!=0. In that case MISALIGNED=1, no bus access, BUSYWAIT=0, DMEM_OUT=0.
- Illegal cases, treated exactly as misaligned:
  - FUNC3 011/110/111 on a load.
  - FUNC3 other than 000–010 on a store.
  - MEM_READ and MEM_WRITE both high.
- Reset (RESET_N low, any state, takes effect immediately):
  - state IDLE, data register 0, bus registers 0.
  - all outputs 0 except MISALIGNED, which stays combinational.
  - An in-flight transaction is abandoned; a late MEM_ACK arriving in IDLE is ignored.

## Timing
- Cycle 0: request arrives in IDLE, BUSYWAIT high combinationally.
- Cycle 1: WAIT, MEM_REQ high. ACK in cycle k>=1 -> DONE in cycle k+1.
- In DONE, BUSYWAIT is low and DMEM_OUT is valid; MEM/WB captures it at the end of that cycle.
- Minimum occupancy is 3 cycles (ACK in the first WAIT cycle).
- MEM_ACK is sampled only in WAIT.
- MISALIGNED requests complete in 0 stall cycles.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A 10-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ACK: go to DONE, data register 0, BUS_ERROR high for that DONE cycle.
  - ACK in the same cycle as expiry wins: normal completion, no error.
- DMEM_TIMEOUT_EN undefined: no counter, BUS_ERROR tied 0, WAIT persists until ACK.

## Structure
- Package dmem_pkg holds:
  - FSM state enum (IDLE/WAIT/DONE).
  - FUNC3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - A default for TIMEOUT_CYCLES.
- One combinational sub-module, dmem_align, contains:
  - store lane replication and BE generation,
  - load lane select and extension,
  - misalign/illegal detection.
- FSM, bus registers and timeout counter live in the top module.

## Test plan
- LW at 0x100, RDATA 0xDEADBEEF, ACK after 2 WAIT cycles -> BUSYWAIT high 3 cycles, DONE with DMEM_OUT 0xDEADBEEF, MEM_BE 1111.
- LB at 0x103, RDATA 0x80FF_0000 -> DMEM_OUT 0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH rs2=0x1234ABCD at 0x0E -> MEM_WE 1, MEM_ADDR 0x3, MEM_BE 1100, MEM_WDATA 0xABCDABCD.
- LW at 0x102 -> MISALIGNED 1, MEM_REQ never high, BUSYWAIT 0, DMEM_OUT 0.
- RESET_N dropped mid-WAIT, then ACK -> MEM_REQ 0 immediately, state IDLE, ACK ignored, all outputs 0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES 4, no ACK -> DONE after 4 WAIT cycles, BUS_ERROR one-cycle pulse, DMEM_OUT 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Optional timeout logic in the top is enabled with the DMEM_TIMEOUT_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    // Registered bus-side request, cleared to zero outside WAIT.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    // Extends a lane that has already been shifted down to bit 0.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] lane);
        logic [31:0] res;
        case (f3)
            F3_B:    res = {{24{lane[7]}}, lane[7:0]};
            F3_H:    res = {{16{lane[15]}}, lane[15:0]};
            F3_W:    res = lane;
            F3_BU:   res = {24'd0, lane[7:0]};
            F3_HU:   res = {16'd0, lane[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and replication, load lane
// select/extension, and misaligned/illegal request detection.
module dmem_align
    import dmem_pkg::*;
(
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic        bad_align_s;
    logic        f3_ok_s;
    logic [31:0] lane_s;

    // Request decode: width-dependent byte enables, alignment and legality.
    always_comb begin
        be          = 4'b0000;
        wdata_rep   = 32'd0;
        bad_align_s = 1'b0;
        f3_ok_s     = 1'b0;
        case (func3)
            F3_B, F3_BU: begin
                be          = 4'b0001 << addr_lo;
                bad_align_s = 1'b0;
            end
            F3_H, F3_HU: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                bad_align_s = addr_lo[0];
            end
            F3_W: begin
                be          = 4'b1111;
                bad_align_s = (addr_lo != 2'b00);
            end
            default: begin
                be          = 4'b0000;
                bad_align_s = 1'b1;
            end
        endcase
        if (mem_write) begin
            f3_ok_s = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
            case (func3)
                F3_B:    wdata_rep = {4{wdata[7:0]}};
                F3_H:    wdata_rep = {2{wdata[15:0]}};
                F3_W:    wdata_rep = wdata;
                default: wdata_rep = 32'd0;
            endcase
        end else begin
            f3_ok_s = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                      (func3 == F3_BU) || (func3 == F3_HU);
        end
        misaligned = (mem_read & mem_write) |
                     ((mem_read ^ mem_write) & (~f3_ok_s | bad_align_s));
    end

    // Load path works from the captured width/offset, not the live request.
    always_comb begin
        lane_s    = rdata >> {ld_off, 3'b000};
        load_data = extend_load(ld_func3, lane_s);
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: IDLE/WAIT/DONE handshake with the data bus.
// Define DMEM_TIMEOUT_EN to add the WAIT-state timeout and BUS_ERROR pulse.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] DMEM_OUT,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    state_t      state_q, state_d;
    bus_t        bus_q, bus_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] data_q, data_d;

    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic [31:0] load_data_s;
    logic        misaligned_s;
    logic        valid_s;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    dmem_align u_align (
        .mem_read   (MEM_READ),
        .mem_write  (MEM_WRITE),
        .func3      (FUNC3),
        .addr_lo    (ADDRESS[1:0]),
        .wdata      (WRITE_DATA),
        .ld_func3   (ld_f3_q),
        .ld_off     (ld_off_q),
        .rdata      (MEM_RDATA),
        .be         (be_s),
        .wdata_rep  (wdata_rep_s),
        .load_data  (load_data_s),
        .misaligned (misaligned_s)
    );

    assign valid_s = (MEM_READ ^ MEM_WRITE) & ~misaligned_s;

    // Next-state, bus capture and load-data capture.
    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        data_d   = data_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_s) begin
                    state_d       = S_WAIT;
                    bus_d.req     = 1'b1;
                    bus_d.we      = MEM_WRITE;
                    bus_d.addr    = ADDRESS[31:2];
                    bus_d.be      = be_s;
                    bus_d.wdata   = wdata_rep_s;
                    ld_f3_d       = FUNC3;
                    ld_off_d      = ADDRESS[1:0];
                    data_d        = 32'd0;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d         = 10'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (MEM_ACK) begin
                    state_d = S_DONE;
                    bus_d   = '0;
                    data_d  = bus_q.we ? 32'd0 : load_data_s;
`ifdef DMEM_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_DONE;
                    bus_d   = '0;
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 10'd1;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                bus_d   = '0;
                data_d  = 32'd0;
            end
        endcase
    end

    // State and capture registers; reset abandons any in-flight access.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            bus_q    <= '0;
            ld_f3_q  <= 3'd0;
            ld_off_q <= 2'd0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            data_q   <= data_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Timeout counter and error flag (flag is only ever set for the DONE cycle).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= 10'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign BUS_ERROR = err_q;
`else
    assign BUS_ERROR = 1'b0;
`endif

    // Reset gates the stall so every output except MISALIGNED reads 0 in reset.
    assign BUSYWAIT   = RESET_N & (((state_q == S_IDLE) & valid_s) | (state_q == S_WAIT));
    assign MISALIGNED = misaligned_s;
    assign DMEM_OUT   = (state_q == S_DONE) ? data_q : 32'd0;
    assign MEM_REQ    = bus_q.req;
    assign MEM_WE     = bus_q.we;
    assign MEM_ADDR   = bus_q.addr;
    assign MEM_BE     = bus_q.be;
    assign MEM_WDATA  = bus_q.wdata;

endmodule
